uart_tx_arbiter: RTL and testbench

//   Shares a single UART transmitter among N_REQ byte requesters (e.g. the loopback

---
 rtl/uart_tx_arbiter.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among N_REQ byte requesters.
// Round-robin arbitration, one byte per grant, handshake with the TX core via
// tx_start/tx_busy, and an optional idle gap of GAP_CYC cycles after each byte.
// Optional feature macro: UART_ARB_PKT_LOCK_EN (keeps the grant on one requester
// until it presents a byte with req_last set).
module uart_tx_arbiter #(
   parameter int N_REQ   = 4,
   parameter int DATA_W  = 8,
   parameter int GAP_CYC = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   input  logic [N_REQ-1:0]          req_last,
   output logic [N_REQ-1:0]          req_ready,
   output logic [DATA_W-1:0]         tx_data,
   output logic                      tx_start,
   input  logic                      tx_busy,
   output logic [$clog2(N_REQ)-1:0]  grant_id,
   output logic                      grant_valid
);

   localparam int ID_W  = $clog2(N_REQ);
   localparam int IDX_W = ID_W + 1;
   localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_GAP
   } state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   grant_q, grant_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [7:0]        gap_q, gap_d;

   logic [N_REQ-1:0]  elig;
   logic              found;
   logic [ID_W-1:0]   pick;
   logic [ID_W-1:0]   pick_nxt;
   logic [DATA_W-1:0] req_byte [N_REQ];

   // Unpack the flat data bus into one byte per requester.
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign req_byte[gi] = req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

`ifdef UART_ARB_PKT_LOCK_EN
   logic lock_q, lock_d;

   // While a packet is in progress only its owner may be granted.
   always_comb begin
      elig = lock_q ? (req_valid & (ONE_HOT0 << grant_q)) : req_valid;
   end
`else
   logic unused_last;
   assign unused_last = ^req_last;

   // Every byte is arbitrated afresh.
   always_comb begin
      elig = req_valid;
   end
`endif

   // Round-robin search: first eligible requester at or after the pointer.
   always_comb begin
      logic [IDX_W-1:0] idx;
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = {1'b0, ptr_q} + IDX_W'(k);
         if (idx >= IDX_W'(N_REQ)) begin
            idx = idx - IDX_W'(N_REQ);
         end
         if (!found && elig[idx[ID_W-1:0]]) begin
            found = 1'b1;
            pick  = idx[ID_W-1:0];
         end
      end
      pick_nxt = (pick == ID_W'(N_REQ - 1)) ? '0 : pick + ID_W'(1);
   end

   // Next-state logic for the grant / handshake / gap sequence.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      data_d  = data_q;
      gap_d   = gap_q;
`ifdef UART_ARB_PKT_LOCK_EN
      lock_d  = lock_q;
`endif
      case (state_q)
         S_IDLE: begin
            // A busy transmitter blocks new grants even with requests pending.
            if (!tx_busy && found) begin
               grant_d = pick;
               data_d  = req_byte[pick];
               ptr_d   = pick_nxt;
`ifdef UART_ARB_PKT_LOCK_EN
               lock_d  = !req_last[pick];
`endif
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) begin
               if (GAP_CYC == 0) begin
                  state_d = S_IDLE;
               end else begin
                  gap_d   = 8'(GAP_CYC - 1);
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (gap_q == 8'd0) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         data_q  <= '0;
         gap_q   <= '0;
`ifdef UART_ARB_PKT_LOCK_EN
         lock_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         gap_q   <= gap_d;
`ifdef UART_ARB_PKT_LOCK_EN
         lock_q  <= lock_d;
`endif
      end
   end

   // Outputs decode straight from registered state, so they are glitch-free.
   always_comb begin
      tx_start    = (state_q == S_ISSUE);
      req_ready   = tx_start ? (ONE_HOT0 << grant_q) : '0;
      grant_valid = (state_q != S_IDLE);
      tx_data     = data_q;
      grant_id    = grant_q;
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed tests for uart_tx_arbiter (4 requesters).
// Instance dut uses GAP_CYC=0, instance dut_gap uses GAP_CYC=3; both share inputs.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic        tx_busy;

   logic [3:0]  req_ready,   req_ready_g;
   logic [7:0]  tx_data,     tx_data_g;
   logic        tx_start,    tx_start_g;
   logic [1:0]  grant_id,    grant_id_g;
   logic        grant_valid, grant_valid_g;

   int tests_run    = 0;
   int tests_failed = 0;

   uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .GAP_CYC(0)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
      .tx_start(tx_start), .tx_busy(tx_busy), .grant_id(grant_id),
      .grant_valid(grant_valid)
   );

   uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .GAP_CYC(3)) dut_gap (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready_g), .tx_data(tx_data_g),
      .tx_start(tx_start_g), .tx_busy(tx_busy), .grant_id(grant_id_g),
      .grant_valid(grant_valid_g)
   );

   always #5 clk = ~clk;

   // Protocol watch: at most one ready, and ready only together with tx_start.
   always @(negedge clk) begin
      if (rst === 1'b0 && req_ready !== 4'b0000 &&
          (tx_start !== 1'b1 || (req_ready & (req_ready - 4'd1)) !== 4'b0000)) begin
         tests_run++;
         tests_failed++;
         $display("FAIL ready_protocol: req_ready=%b tx_start=%b, need onehot ready with tx_start", req_ready, tx_start);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      tx_busy   = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic set_req(input int i, input logic [7:0] d, input logic last);
      req_data[8*i +: 8] = d;
      req_last[i]        = last;
      req_valid[i]       = 1'b1;
   endtask

   // Waits for a start pulse, checks the grant, then plays a 6-cycle TX frame.
   task automatic xfer(input string name, input int exp_id, input logic [7:0] exp_data);
      int         n;
      logic [3:0] exp_rdy;
      logic [1:0] exp_gid;
      n       = 0;
      exp_rdy = 4'b0001 << exp_id;
      exp_gid = 2'(exp_id);
      while (tx_start !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      tests_run++;
      if (tx_start !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s_start: tx_start=%b after %0d cycles, need 1", name, tx_start, n);
      end else begin
         $display("[TB] %s: grant_id=%0d tx_data=%h req_ready=%b", name, grant_id, tx_data, req_ready);
         tests_run++;
         if (grant_id !== exp_gid || tx_data !== exp_data || req_ready !== exp_rdy || grant_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_grant: id=%0d data=%h ready=%b gv=%b, need id=%0d data=%h ready=%b gv=1",
                     name, grant_id, tx_data, req_ready, grant_valid, exp_gid, exp_data, exp_rdy);
         end
      end
      tx_busy = 1'b1;
      tick();
      tests_run++;
      if (tx_start !== 1'b0 || req_ready !== 4'b0000) begin
         tests_failed++;
         $display("FAIL %s_pulse: tx_start=%b req_ready=%b one cycle later, need 0 and 0000", name, tx_start, req_ready);
      end
      repeat (5) tick();
      tx_busy = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      tests_run++;
      if (tx_start !== 1'b0 || req_ready !== 4'b0000 || tx_data !== 8'h00 ||
          grant_id !== 2'd0 || grant_valid !== 1'b0 || grant_valid_g !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset: start=%b ready=%b data=%h id=%0d gv=%b gvg=%b, need all zero",
                  tx_start, req_ready, tx_data, grant_id, grant_valid, grant_valid_g);
      end
   endtask

   task automatic test_single();
      apply_reset();
      set_req(1, 8'h55, 1'b1);
      xfer("single", 1, 8'h55);
      req_valid = '0;
      tick();
      tick();
      tests_run++;
      if (grant_valid !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h55 || grant_id !== 2'd1) begin
         tests_failed++;
         $display("FAIL single_idle: gv=%b start=%b data=%h id=%0d, need gv=0 start=0 data=55 id=1",
                  grant_valid, tx_start, tx_data, grant_id);
      end
   endtask

   task automatic test_round_robin();
      apply_reset();
      for (int i = 0; i < 4; i++) set_req(i, 8'(8'h10 + i), 1'b1);
      for (int k = 0; k < 6; k++) xfer($sformatf("rr%0d", k), k % 4, 8'(8'h10 + (k % 4)));
      req_valid = '0;
   endtask

   task automatic test_busy_block();
      int starts;
      apply_reset();
      tx_busy = 1'b1;
      set_req(0, 8'h3C, 1'b1);
      starts = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (tx_start !== 1'b0) starts++;
      end
      tests_run++;
      if (starts != 0) begin
         tests_failed++;
         $display("FAIL busy_hold: %0d start cycles while busy, need 0", starts);
      end
      tx_busy = 1'b0;
      tick();
      tests_run++;
      if (tx_start !== 1'b1) begin
         tests_failed++;
         $display("FAIL busy_release: tx_start=%b one cycle after busy low, need 1", tx_start);
      end
      xfer("busy_xfer", 0, 8'h3C);
      req_valid = '0;
   endtask

   task automatic test_packet_lock();
      int         exp_ids [4];
      logic [7:0] exp_dat [4];
      int         r0;
`ifdef UART_ARB_PKT_LOCK_EN
      exp_ids = '{0, 0, 0, 1};
      exp_dat = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};
`else
      exp_ids = '{0, 1, 0, 1};
      exp_dat = '{8'hA1, 8'hB0, 8'hA2, 8'hB0};
`endif
      apply_reset();
      set_req(0, 8'hA1, 1'b0);
      set_req(1, 8'hB0, 1'b1);
      r0 = 0;
      for (int k = 0; k < 4; k++) begin
         xfer($sformatf("pkt%0d", k), exp_ids[k], exp_dat[k]);
         if (exp_ids[k] == 0) begin
            r0++;
            if (r0 == 1) set_req(0, 8'hA2, 1'b0);
            else if (r0 == 2) set_req(0, 8'hA3, 1'b1);
            else req_valid[0] = 1'b0;
         end
      end
      req_valid = '0;
   endtask

   task automatic test_gap();
      int first0, firstg;
      logic gv3, gv4;
      apply_reset();
      set_req(0, 8'h77, 1'b1);
      tick();
      tests_run++;
      if (tx_start !== 1'b1 || tx_start_g !== 1'b1) begin
         tests_failed++;
         $display("FAIL gap_first: start=%b start_gap=%b, need 1 and 1", tx_start, tx_start_g);
      end
      tx_busy = 1'b1;
      repeat (4) tick();
      tx_busy = 1'b0;
      first0 = -1;
      firstg = -1;
      gv3    = 1'bx;
      gv4    = 1'bx;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (tx_start === 1'b1 && first0 < 0) first0 = k;
         if (tx_start_g === 1'b1 && firstg < 0) firstg = k;
         if (k == 3) gv3 = grant_valid_g;
         if (k == 4) gv4 = grant_valid_g;
      end
      $display("[TB] gap: restart after %0d cycles (gap 0), %0d cycles (gap 3)", first0, firstg);
      tests_run++;
      if (first0 != 2) begin
         tests_failed++;
         $display("FAIL gap0_restart: tx_start after %0d cycles, need 2", first0);
      end
      tests_run++;
      if (firstg != 5) begin
         tests_failed++;
         $display("FAIL gap3_restart: tx_start after %0d cycles, need 5", firstg);
      end
      tests_run++;
      if (gv3 !== 1'b1 || gv4 !== 1'b0) begin
         tests_failed++;
         $display("FAIL gap3_grant_valid: last gap cycle %b then idle %b, need 1 then 0", gv3, gv4);
      end
      req_valid = '0;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      set_req(1, 8'h99, 1'b1);
      tick();
      tests_run++;
      if (tx_start !== 1'b1 || grant_id !== 2'd1) begin
         tests_failed++;
         $display("FAIL mid_pre: start=%b id=%0d, need 1 and 1", tx_start, grant_id);
      end
      tx_busy = 1'b1;
      tick();
      tick();
      rst       = 1'b1;
      req_valid = '0;
      tick();
      tests_run++;
      if (tx_start !== 1'b0 || req_ready !== 4'b0000 || tx_data !== 8'h00 ||
          grant_id !== 2'd0 || grant_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_reset: start=%b ready=%b data=%h id=%0d gv=%b, need all zero",
                  tx_start, req_ready, tx_data, grant_id, grant_valid);
      end
      rst     = 1'b0;
      tx_busy = 1'b0;
      set_req(1, 8'h61, 1'b1);
      set_req(3, 8'h63, 1'b1);
      xfer("mid_ptr", 1, 8'h61);
      req_valid = '0;
      tick();
      tick();
      set_req(2, 8'h62, 1'b1);
      xfer("mid_req2", 2, 8'h62);
      req_valid = '0;
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      tx_busy   = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_busy_block();
      test_packet_lock();
      test_gap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
